countdown_bcd_timer: RTL and testbench



---
 rtl/countdown_bcd_timer_pkg.sv | 21 ++
 rtl/countdown_bcd_timer_bcd_down_digit.sv | 41 ++++
 rtl/countdown_bcd_timer.sv | 116 +++++++++++
 tb/tb_countdown_bcd_timer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/countdown_bcd_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package countdown_bcd_timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Clamp a non-decimal nibble to 9 so a digit never holds an illegal code.
  function automatic logic [DIGIT_W-1:0] bcd_sanitize(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/countdown_bcd_timer_bcd_down_digit.sv
// One modulo-10 down-counting BCD digit with parallel load and borrow chain.
module bcd_down_digit
  import countdown_bcd_timer_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               borrow_in_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               borrow_out_c
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  // Next digit value: load wins, otherwise decrement with 0 -> 9 wrap.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (borrow_in_i) begin
      digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : (digit_q - 4'd1);
    end
  end

  // Borrow to the next digit when decrementing through zero.
  assign borrow_out_c = borrow_in_i && (digit_q == BCD_ZERO);

  // Digit register, updated on the falling clock edge.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/countdown_bcd_timer.sv
// Cascaded BCD countdown timer with load, start/pause control and done flag.
module countdown_bcd_timer
  import countdown_bcd_timer_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] load_value,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      tick,
  output logic [DIGIT_W*DIGITS-1:0] Q,
  output logic                      running,
  output logic                      done
);

  localparam int unsigned QW = DIGIT_W * DIGITS;

  state_e          state_q;
  state_e          state_d;
  logic            running_q;
  logic            running_d;
  logic            done_q;
  logic            done_d;

  logic [QW-1:0]   q_c;
  logic [QW-1:0]   load_san_c;
  logic            is_zero_c;
  logic            is_one_c;
  logic            dec_c;
  logic [DIGITS:0] borrow_c;

  // Clamp every loaded digit into the 0..9 range.
  always_comb begin
    load_san_c = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      load_san_c[i*DIGIT_W +: DIGIT_W] = bcd_sanitize(load_value[i*DIGIT_W +: DIGIT_W]);
    end
  end

  assign is_zero_c = (q_c == '0);
  assign is_one_c  = (q_c == QW'(1));

  // Decrement only in RUN on a tick that is not overridden by load or pause.
  assign dec_c = (state_q == ST_RUN) && !load && !pause && tick && !is_zero_c;

  assign borrow_c[0] = dec_c;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_down_digit u_digit (
      .clock        (clock),
      .reset        (reset),
      .load_i       (load),
      .load_val_i   (load_san_c[g*DIGIT_W +: DIGIT_W]),
      .borrow_in_i  (borrow_c[g]),
      .digit_o      (q_c[g*DIGIT_W +: DIGIT_W]),
      .borrow_out_c (borrow_c[g+1])
    );
  end

  // The counter must never borrow out of the top digit (no wrap below zero).
  no_underflow_a : assert property (@(negedge clock) disable iff (!reset) !borrow_c[DIGITS]);

  // State register plus registered status flags.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; load overrides everything, pause beats start in RUN.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = is_zero_c ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (pause)                 state_d = ST_PAUSED;
          else if (tick && is_one_c) state_d = ST_DONE;
        end
        ST_PAUSED: begin
          if (start) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Status flags follow the state being entered so they line up with Q.
  always_comb begin
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  assign Q       = q_c;
  assign running = running_q;
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_bcd_timer.sv
// Scoreboard bench for countdown_bcd_timer (2-digit and 3-digit instances).
module tb_countdown_bcd_timer;

  logic        clock;
  logic        reset;
  logic        load;
  logic        start;
  logic        pause;
  logic        tick;
  logic [7:0]  lv2;
  logic [11:0] lv3;
  logic [7:0]  q2;
  logic [11:0] q3;
  logic        run2, done2, run3, done3;

  typedef struct packed {
    logic        sel;
    logic [11:0] q;
    logic        run;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   errors;
  int   checks;

  countdown_bcd_timer #(.DIGITS(2)) dut2 (
    .clock(clock), .reset(reset), .load(load), .load_value(lv2),
    .start(start), .pause(pause), .tick(tick),
    .Q(q2), .running(run2), .done(done2)
  );

  countdown_bcd_timer #(.DIGITS(3)) dut3 (
    .clock(clock), .reset(reset), .load(load), .load_value(lv3),
    .start(start), .pause(pause), .tick(tick),
    .Q(q3), .running(run3), .done(done3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Drive one edge's inputs and queue the response expected after that edge.
  task automatic step(input logic sel, input logic ld, input logic [11:0] lv,
                      input logic st, input logic pa, input logic tk,
                      input logic [11:0] eq, input logic er, input logic ed);
    exp_t e;
    @(posedge clock);
    load  = ld;
    lv2   = lv[7:0];
    lv3   = lv;
    start = st;
    pause = pa;
    tick  = tk;
    e.sel  = sel;
    e.q    = eq;
    e.run  = er;
    e.done = ed;
    exp_q.push_back(e);
  endtask

  // Monitor: after each active (falling) edge, compare against the queue head.
  initial begin
    forever begin
      exp_t e;
      @(negedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel) begin
          check("dut3 Q", q3, e.q);
          check("dut3 running", {11'd0, run3}, {11'd0, e.run});
          check("dut3 done", {11'd0, done3}, {11'd0, e.done});
        end else begin
          check("dut2 Q", {4'd0, q2}, e.q);
          check("dut2 running", {11'd0, run2}, {11'd0, e.run});
          check("dut2 done", {11'd0, done2}, {11'd0, e.done});
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    load = 0; start = 0; pause = 0; tick = 0; lv2 = '0; lv3 = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset Q", {4'd0, q2}, 12'h000);
    check("reset running", {11'd0, run2}, 12'h000);
    check("reset done", {11'd0, done2}, 12'h000);
    @(posedge clock);
    reset = 1'b1;

    // Reset in the middle of RUN clears outputs without a clock edge.
    step(0, 1, 12'h037, 0, 0, 0, 12'h037, 0, 0);
    step(0, 0, 12'h000, 1, 0, 0, 12'h037, 1, 0);
    step(0, 0, 12'h000, 0, 0, 1, 12'h036, 1, 0);
    @(negedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("async reset Q", {4'd0, q2}, 12'h000);
    check("async reset running", {11'd0, run2}, 12'h000);
    check("async reset done", {11'd0, done2}, 12'h000);
    @(posedge clock);
    reset = 1'b1;
    // Tick in IDLE is ignored; start at zero goes straight to DONE.
    step(0, 0, 12'h000, 0, 0, 1, 12'h000, 0, 0);
    step(0, 0, 12'h000, 1, 0, 0, 12'h000, 0, 1);

    // Full countdown from 25 with continuous ticks, then extra ticks in DONE.
    step(0, 1, 12'h025, 0, 0, 0, 12'h025, 0, 0);
    step(0, 0, 12'h000, 1, 0, 0, 12'h025, 1, 0);
    for (int i = 1; i <= 25; i++) begin
      step(0, 0, 12'h000, 0, 0, 1, to_bcd(25 - i), (i < 25), (i == 25));
    end
    for (int i = 0; i < 3; i++) step(0, 0, 12'h000, 0, 0, 1, 12'h000, 0, 1);
    step(0, 0, 12'h000, 1, 1, 1, 12'h000, 0, 1);

    // Borrow from the tens digit.
    step(0, 1, 12'h010, 0, 0, 0, 12'h010, 0, 0);
    step(0, 0, 12'h000, 1, 0, 0, 12'h010, 1, 0);
    step(0, 0, 12'h000, 0, 0, 1, 12'h009, 1, 0);

    // Load zero then start: DONE without ever running.
    step(0, 1, 12'h000, 0, 0, 0, 12'h000, 0, 0);
    step(0, 0, 12'h000, 1, 0, 0, 12'h000, 0, 1);

    // Pause wins over tick; held value survives ticks; resume then tick.
    step(0, 1, 12'h042, 0, 0, 0, 12'h042, 0, 0);
    step(0, 0, 12'h000, 1, 0, 0, 12'h042, 1, 0);
    step(0, 0, 12'h000, 0, 1, 1, 12'h042, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 12'h000, 0, (i < 2), 1, 12'h042, 0, 0);
    step(0, 0, 12'h000, 1, 0, 0, 12'h042, 1, 0);
    step(0, 0, 12'h000, 0, 0, 1, 12'h041, 1, 0);

    // Illegal digit clamps to 9; load beats start and tick.
    step(0, 1, 12'h0A7, 0, 0, 0, 12'h097, 0, 0);
    step(0, 1, 12'h055, 1, 0, 0, 12'h055, 0, 0);
    step(0, 0, 12'h000, 1, 0, 0, 12'h055, 1, 0);
    step(0, 1, 12'h030, 1, 1, 1, 12'h030, 0, 0);
    step(0, 0, 12'h000, 0, 0, 1, 12'h030, 0, 0);

    // Three-digit instance: 100 down to 000.
    step(1, 1, 12'h100, 0, 0, 0, 12'h100, 0, 0);
    step(1, 0, 12'h000, 1, 0, 0, 12'h100, 1, 0);
    step(1, 0, 12'h000, 0, 0, 1, 12'h099, 1, 0);
    for (int i = 1; i <= 99; i++) begin
      step(1, 0, 12'h000, 0, 0, 1, to_bcd(99 - i), (i < 99), (i == 99));
    end
    step(1, 0, 12'h000, 0, 0, 1, 12'h000, 0, 1);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
